// File: rtl/up_down_cmd_gen.sv
// Pushbutton command generator: synchronise, debounce and press-detect up/down/clear buttons into
// single-cycle up_dwn codes. Define AUTO_REPEAT_EN to add hold-to-repeat on up/down.

module up_down_cmd_gen_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // level only flips once the input has disagreed for DEBOUNCE_CYCLES+1 cycles in a row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_b == level) begin
      cnt <= '0;
    end else if (cnt == CNT_TC) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

module up_down_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dwn,
  input  logic       btn_clr,
  output logic [1:0] up_dwn,
  output logic [2:0] btn_state
);
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DWN  = 2'b10;
  localparam logic [1:0] CMD_CLR  = 2'b11;

  logic [2:0] raw;
  logic [2:0] level;
  logic [2:0] rise;
  logic       rep_fire;
  logic [1:0] rep_code;
  logic [1:0] cmd_next;

  assign raw = {btn_clr, btn_dwn, btn_up};

  for (genvar i = 0; i < 3; i++) begin : g_deb
    up_down_cmd_gen_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .level(level[i])
    );
  end

  // btn_state is the previous debounced level, so it doubles as the edge detector's history
  assign rise = level & ~btn_state;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RELOAD_DELAY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RELOAD_PERIOD = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_tmr;
  logic          rep_active;

  // runs only while a single direction is held and nothing new was pressed this cycle
  assign rep_active = (level[0] ^ level[1]) & ~level[2] & ~(|rise);
  assign rep_fire   = rep_active & (rep_tmr == '0);
  assign rep_code   = level[0] ? CMD_UP : CMD_DWN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_tmr <= '0;
    end else if (!rep_active) begin
      rep_tmr <= RELOAD_DELAY;
    end else if (rep_tmr == '0) begin
      rep_tmr <= RELOAD_PERIOD;
    end else begin
      rep_tmr <= rep_tmr - RW'(1);
    end
  end
`else
  logic unused_repeat_cfg;

  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire          = 1'b0;
  assign rep_code          = CMD_IDLE;
`endif

  always_comb begin
    cmd_next = CMD_IDLE;
    if (rise[2]) begin
      cmd_next = CMD_CLR;
    end else if (rise[0] && rise[1]) begin
      cmd_next = CMD_IDLE;
    end else if (rise[0]) begin
      cmd_next = CMD_UP;
    end else if (rise[1]) begin
      cmd_next = CMD_DWN;
    end else if (rep_fire) begin
      cmd_next = rep_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_dwn    <= CMD_IDLE;
      btn_state <= 3'b000;
    end else begin
      up_dwn    <= cmd_next;
      btn_state <= level;
    end
  end
endmodule
